// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : arbiter and sequencer for one shared single-port memory
//               (fetch vs. load/store), with a bounded data-burst rule
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_d_q, owner_d_d;   // 1 = data requester owns the access
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

  logic grant_d, grant_i;

  always_comb begin
    state_d   = state_q;
    owner_d_d = owner_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    burst_d   = burst_q;
    grant_d   = 1'b0;
    grant_i   = 1'b0;

    case (state_q)
      IDLE: begin
        // A waiting fetch wins only once data has used up its burst allowance.
        grant_d = d_req && !(if_req && (burst_q == BURST_MAX));
        grant_i = if_req && !grant_d;
        if (grant_d) begin
          owner_d_d = 1'b1;
          we_d      = d_we;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          state_d   = ACCESS;
          if (!if_req)
            burst_d = '0;
          else if (burst_q != BURST_MAX)
            burst_d = burst_q + 1'b1;
        end else if (grant_i) begin
          owner_d_d = 1'b0;
          we_d      = 1'b0;
          addr_d    = if_addr;
          wdata_d   = '0;
          burst_d   = '0;
          state_d   = ACCESS;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_d_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      burst_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      burst_q   <= burst_d;
      if (state_q == ACCESS && !we_q) begin
        if (owner_d_q)
          d_rdata_q <= mem_read_data;
        else
          if_rdata_q <= mem_read_data;
      end
    end
  end

  // Memory strobes are gated by ACCESS so nothing reaches the memory otherwise.
  assign mem_addr       = (state_q == ACCESS) ? addr_q : '0;
  assign mem_write_data = (state_q == ACCESS && we_q) ? wdata_q : '0;
  assign mem_MemWrite   = (state_q == ACCESS) && we_q;
  assign mem_MemRead    = (state_q == ACCESS) && !we_q;

  assign if_ack   = (state_q == DONE) && !owner_d_q;
  assign d_ack    = (state_q == DONE) && owner_d_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : self-checking bench for mem_arbiter with a 64-word memory
//                  model and an expected-ack scoreboard
// Revision       : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] mem_snap [64];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i * 17);
    mem[5] = 32'h2002_000A;
  end

  always @(posedge clk) if (mem_MemWrite) mem[mem_addr[5:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_addr[5:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic              is_d;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   ack_count  = 0;
  int   wr_cycles  = 0;
  string grant_log = "";

  task automatic push_exp(input logic is_d, input logic [DATA_W-1:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mem_MemWrite) wr_cycles++;
    if (!rst && (if_ack || d_ack)) begin
      exp_t e;
      check("ack_exclusive", 64'(if_ack & d_ack), 64'd0);
      ack_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_owner", 64'(d_ack), 64'(e.is_d));
        check("ack_rdata", e.is_d ? 64'(d_rdata) : 64'(if_rdata), 64'(e.data));
      end
    end
  end

  task automatic data_txn(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    bit got = 0;
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_ack) got = 1;
    end
    if (!got) check("d_ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic fetch_txn(input logic [ADDR_W-1:0] a);
    bit got = 0;
    if_addr = a; if_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (if_ack) got = 1;
    end
    if (!got) check("if_ack_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    int wr0;
    int base;
    int diffs;
    bit done;

    // Reset with both requests pending
    if_req = 1'b1; if_addr = 3;
    d_req  = 1'b1; d_addr  = 7; d_we = 1'b0;
    rst    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mem", {mem_addr, mem_write_data} | 64'({mem_MemWrite, mem_MemRead}), 64'd0);
      check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    end
    push_exp(1'b1, mem[7]);
    push_exp(1'b0, mem[3]);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_first_access_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_first_access_read", 64'(mem_MemRead), 64'd1);
    check("rst_first_access_addr", 64'(mem_addr), 64'd7);
    fork
      data_txn(1'b0, 7, '0);
      fetch_txn(3);
    join

    // Single fetch with exact latency
    push_exp(1'b0, 32'h2002_000A);
    if_addr = 5; if_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("fetch_access_read", 64'(mem_MemRead), 64'd1);
    check("fetch_access_addr", 64'(mem_addr), 64'd5);
    @(negedge clk);
    check("fetch_ack", 64'(if_ack), 64'd1);
    check("fetch_rdata", 64'(if_rdata), 64'h2002_000A);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Store then load
    wr0 = wr_cycles;
    push_exp(1'b1, mem[7]);
    data_txn(1'b1, 9, 32'hDEAD_BEEF);
    check("store_write_cycles", 64'(wr_cycles - wr0), 64'd1);
    check("store_mem_word", 64'(mem[9]), 64'hDEAD_BEEF);
    push_exp(1'b1, 32'hDEAD_BEEF);
    data_txn(1'b0, 9, '0);

    // Both requesters held continuously: D,D,D,D,I,D,D,D,D,I
    for (int k = 0; k < 10; k++)
      push_exp((k % 5) != 4, ((k % 5) != 4) ? mem[7] : mem[3]);
    base = ack_count;
    done = 0;
    if_addr = 3; d_addr = 7; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); #1;
      if (ack_count - base >= 10) done = 1;
    end
    if (!done) check("fair_timeout", 64'(ack_count - base), 64'd10);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    check("fair_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset during ACCESS drops the load
    d_addr = 5; d_we = 1'b0; d_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstacc_in_access", 64'(mem_MemRead), 64'd1);
    rst = 1'b1; d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstacc_no_ack", 64'(d_ack), 64'd0);
    check("rstacc_idle", 64'(busy), 64'd0);
    check("rstacc_rdata_cleared", 64'(d_rdata), 64'd0);
    @(negedge clk);
    check("rstacc_still_no_ack", 64'(d_ack), 64'd0);
    @(posedge clk); #1;
    push_exp(1'b1, 32'h2002_000A);
    data_txn(1'b0, 5, '0);

    // Idle bus
    for (int i = 0; i < 64; i++) mem_snap[i] = mem[i];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_strobes", 64'({mem_MemWrite, mem_MemRead, busy}), 64'd0);
    end
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== mem_snap[i]) diffs++;
    check("idle_mem_unchanged", 64'(diffs), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer for the multicycle MIPS core. It shares the one 64-word unified memory between the instruction-fetch requester and the load/store requester. Each accepted request becomes exactly one registered memory access, followed by a one-cycle acknowledge. Data accesses have priority over fetches, and a bounded-burst rule keeps fetch from starving.

## Interface
Parameters:
- `ADDR_W`, 32, address width passed through to memory (word-indexed)
- `DATA_W`, 32, data width
- `MAX_DATA_BURST`, 4, consecutive data grants allowed while a fetch is waiting (≥1)

Ports:
- `clk`  in  1  single clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_ack`  out  1  one-cycle pulse; `if_rdata` valid in this cycle
- `if_rdata`  out  DATA_W  fetched word, registered
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_ack`  out  1  one-cycle pulse
- `d_rdata`  out  DATA_W  loaded word, registered
- `mem_addr`  out  ADDR_W  to memory `addr`
- `mem_write_data`  out  DATA_W  to memory `write_data`
- `mem_MemWrite`  out  1  to memory `MemWrite`
- `mem_MemRead`  out  1  to memory `MemRead`
- `mem_read_data`  in  DATA_W  from memory `read_data`; combinational within the cycle
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - Arbitrate on sampled `d_req` / `if_req`.
  - If any request is present, latch the winner's owner, address, we and wdata, then go to ACCESS.
  - Otherwise stay in IDLE.
- **Arbitration rule**
  - Only `d_req`: grant data.
  - Only `if_req`: grant fetch.
  - Both present: grant data unless `burst_cnt == MAX_DATA_BURST`, in which case grant fetch.
- **`burst_cnt`** (width clog2(MAX_DATA_BURST+1))
  - Increments on a data grant while `if_req` = 1, saturating at MAX_DATA_BURST.
  - Clears on any fetch grant, or on a data grant while `if_req` = 0.
- **ACCESS** (exactly one cycle)
  - Drive `mem_addr` from the latched address.
  - Drive `mem_MemWrite` = latched we and `mem_MemRead` = !latched we.
  - Drive `mem_write_data` from latched wdata when we = 1, otherwise 0.
  - For a read, capture `mem_read_data` at the end of the cycle into `if_rdata` or `d_rdata` per owner.
  - The memory commits a write at this same edge.
  - Go to DONE.
- **DONE**
  - Pulse the owner's ack for one cycle, then go to IDLE.
  - The requester deasserts or changes its req in the cycle after ack. IDLE re-samples, so a req still high after ack is a new request.
- **Outside ACCESS**: `mem_addr`, `mem_write_data`, `mem_MemWrite` and `mem_MemRead` are all 0, so no spurious memory writes occur.
- **Read data registers**
  - `if_rdata` and `d_rdata` hold their last loaded value until overwritten.
  - A store leaves `d_rdata` unchanged.
- **Addresses**: passed through unmodified. Address mapping and range are the memory's concern; the arbiter does no range check.
- **Changing inputs**: req inputs that change after acceptance do not affect the transaction in flight, because operands are latched in IDLE.

## Timing
- **Reset** (`rst` = 1 at a posedge):
  - State goes to IDLE and `burst_cnt` to 0.
  - `if_ack`, `d_ack`, `busy`, all `mem_*` outputs, `if_rdata` and `d_rdata` all go to 0.
- **Reset mid-transaction**: the transaction is dropped with no ack, and the requester must reissue.
  - Reset during ACCESS still coincides with that cycle's memory write edge. The memory may commit the store; the spec does not guarantee that it is suppressed.
- **Latency**: a req sampled high in IDLE at edge n gives ACCESS in cycle n+1 and ack in cycle n+2, with rdata valid in that same cycle.
- **Throughput**: one access per 3 cycles. Back-to-back requests: IDLE, ACCESS, DONE, IDLE, ...
- **Simultaneous requests**: both requests rising in the same cycle are resolved by the arbitration rule. The loser keeps req high and is served in the next IDLE.
- **Acks**: `if_ack` and `d_ack` are never high together, and each is high for exactly one cycle per grant.
- **`busy`**: high in ACCESS and DONE.

## Test plan
- **Reset**: assert `rst` for 2 cycles with both reqs high → all outputs 0, no acks; after release, first ACCESS occurs 1 cycle later and is a data grant.
- **Single fetch**: `if_addr` = 5 with memory word 5 = 0x2002000A → `mem_MemRead` = 1 and `mem_addr` = 5 in cycle n+1; `if_ack` = 1 and `if_rdata` = 0x2002000A in cycle n+2.
- **Store then load**: store 0xDEADBEEF to `d_addr` 9, then load 9 → `mem_MemWrite` high for exactly 1 cycle; second `d_ack` returns `d_rdata` = 0xDEADBEEF; `d_rdata` unchanged by the store's ack.
- **Priority/fairness**: `if_req` and `d_req` held high continuously with MAX_DATA_BURST = 4 → grant order D,D,D,D,I,D,D,D,D,I; no cycle with both acks high.
- **Reset during ACCESS**: load in flight, `rst` pulsed in the ACCESS cycle → no `d_ack`, state IDLE, `d_rdata` = 0; a reissued load completes normally.
- **Idle bus**: no reqs for 10 cycles → `mem_MemWrite` = `mem_MemRead` = 0 and `busy` = 0 throughout; memory contents unchanged.
